// File: rtl/lemon_pkg.sv
// Shared types and constants for the lemon core pipeline.
// Writeback FSM states and RV64 load funct3 encodings.
package lemon_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    COMMIT
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/load_extract.sv
// Byte-select and sign/zero-extend an aligned doubleword for RV64 loads.
// Flags illegal funct3 and misaligned halfword/word/doubleword accesses.
module load_extract
  import lemon_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    data = '0;
    err  = 1'b0;
    unique case (funct3)
      F3_LB: begin
        data = {{56{shifted[7]}}, shifted[7:0]};
      end
      F3_LH: begin
        data = {{48{shifted[15]}}, shifted[15:0]};
        err  = addr_lo[0];
      end
      F3_LW: begin
        data = {{32{shifted[31]}}, shifted[31:0]};
        err  = |addr_lo[1:0];
      end
      F3_LD: begin
        data = shifted;
        err  = |addr_lo;
      end
      F3_LBU: begin
        data = {56'd0, shifted[7:0]};
      end
      F3_LHU: begin
        data = {48'd0, shifted[15:0]};
        err  = addr_lo[0];
      end
      F3_LWU: begin
        data = {32'd0, shifted[31:0]};
        err  = |addr_lo[1:0];
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per handshake, waits on
// load data, and drives the register file write port and commit strobe.
module wb_stage
  import lemon_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [2:0]            in_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic [63:0]           in_pc,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_dataD,
  output logic                  commit_valid,
  output logic [63:0]           commit_pc,
  output logic                  wb_err
);

  wb_state_e             state;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  wen_q;
  logic [2:0]            f3_q;
  logic [2:0]            alo_q;
  logic [63:0]           pc_q;
  logic [XLEN-1:0]       ext_data;
  logic                  ext_err;
  logic                  accept;

  // Gated by rst_n so nothing is accepted while reset is held.
  assign in_ready = rst_n && (state != WAIT_MEM);
  assign accept   = in_valid && in_ready;

  load_extract u_extract (
    .rdata   (mem_rdata),
    .addr_lo (alo_q),
    .funct3  (f3_q),
    .data    (ext_data),
    .err     (ext_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_q         <= '0;
      wen_q        <= 1'b0;
      f3_q         <= '0;
      alo_q        <= '0;
      pc_q         <= '0;
      rf_wen       <= 1'b0;
      rf_rd        <= '0;
      rf_dataD     <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      wb_err       <= 1'b0;
    end else begin
      rf_wen       <= 1'b0;
      commit_valid <= 1'b0;
      wb_err       <= 1'b0;
      unique case (state)
        WAIT_MEM: begin
          if (mem_rvalid) begin
            state        <= COMMIT;
            commit_valid <= 1'b1;
            commit_pc    <= pc_q;
            rf_rd        <= rd_q;
            wb_err       <= ext_err;
            rf_wen       <= wen_q && (rd_q != '0) && !ext_err;
            rf_dataD     <= ext_err ? '0 : ext_data;
          end
        end
        IDLE, COMMIT: begin
          if (accept && in_is_load) begin
            state <= WAIT_MEM;
            rd_q  <= in_rd;
            wen_q <= in_wen;
            f3_q  <= in_funct3;
            alo_q <= in_addr_lo;
            pc_q  <= in_pc;
          end else if (accept) begin
            state        <= COMMIT;
            commit_valid <= 1'b1;
            commit_pc    <= in_pc;
            rf_rd        <= in_rd;
            rf_wen       <= in_wen && (in_rd != '0);
            rf_dataD     <= in_result;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
